// File: rtl/matrix_mac_sequencer.sv
// Matrix-vector MAC sequencer: walks each row of A against B in 8-element beats over
// the dual-port ROM bank, accumulates the dot product and checks it against ROM C.
module matrix_mac_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 7,
    parameter int N_ROWS       = 128,
    parameter int N_COLS       = 128,
    parameter int READ_LATENCY = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    output logic [2*ADDR_WIDTH-1:0]             romA_addrA,
    output logic [2*ADDR_WIDTH-1:0]             romA_addrB,
    output logic [ADDR_WIDTH-1:0]               romB_addrA,
    output logic [ADDR_WIDTH-1:0]               romB_addrB,
    output logic [ADDR_WIDTH-1:0]               romC_addrA,
    output logic [ADDR_WIDTH-1:0]               romC_addrB,
    input  logic [3:0][DATA_WIDTH-1:0]          romA_busA_in,
    input  logic [3:0][DATA_WIDTH-1:0]          romA_busB_in,
    input  logic [3:0][DATA_WIDTH-1:0]          romB_busA_in,
    input  logic [3:0][DATA_WIDTH-1:0]          romB_busB_in,
    input  logic [2*DATA_WIDTH-1:0]             romC_dataA_in,
    input  logic [2*DATA_WIDTH-1:0]             romC_dataB_in,
    output logic                                busy,
    output logic                                done,
    output logic                                result_valid,
    output logic [ADDR_WIDTH-1:0]               result_row,
    output logic [2*DATA_WIDTH-1:0]             result_data,
    output logic                                result_match,
    output logic [ADDR_WIDTH:0]                 mismatch_count
);

    localparam int NB  = N_COLS / 8;
    localparam int BW  = $clog2(NB + 1);
    localparam int DRW = $clog2(READ_LATENCY + 2);
    localparam int AW  = ADDR_WIDTH;
    localparam int MW  = ADDR_WIDTH + 1;
    localparam int AW2 = 2 * ADDR_WIDTH;
    localparam int DW2 = 2 * DATA_WIDTH;
    localparam logic [MW-1:0] MISM_MAX = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_row;
    logic [AW-1:0]     w_ld_row;
    logic [BW-1:0]     r_beat;
    logic [BW-1:0]     w_ld_beat;
    logic [DRW-1:0]    r_drain;
    logic [DW2-1:0]    r_acc;
    logic [DW2-1:0]    w_beat_sum;
    logic [READ_LATENCY:0] r_vld_p;
    logic [MW-1:0]     r_mismatch;
    logic [AW2-1:0]    r_a_addr_a;
    logic [AW2-1:0]    r_a_addr_b;
    logic [AW-1:0]     r_b_addr_a;
    logic [AW-1:0]     r_b_addr_b;
    logic [AW2-1:0]    w_a_addr;
    logic [AW-1:0]     w_b_addr;
    logic              w_load;
    logic              w_clr_acc;
    logic              w_accept;
    logic              w_check;
    logic              w_match;
    logic              w_last_beat;
    logic              w_last_row;
    logic              w_drain_end;
    logic              w_unused;

    // Sum of the eight element products of one beat, wrapping at 2*DATA_WIDTH bits.
    function automatic logic [DW2-1:0] mac8(input logic [3:0][DATA_WIDTH-1:0] a0,
                                            input logic [3:0][DATA_WIDTH-1:0] b0,
                                            input logic [3:0][DATA_WIDTH-1:0] a1,
                                            input logic [3:0][DATA_WIDTH-1:0] b1);
        logic [DW2-1:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s = s + DW2'(a0[i]) * DW2'(b0[i]) + DW2'(a1[i]) * DW2'(b1[i]);
        end
        return s;
    endfunction

    function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] v);
        return (v == MISM_MAX) ? v : v + MW'(1);
    endfunction

    assign w_unused    = ^romC_dataB_in;
    assign w_last_beat = (r_beat == BW'(NB - 1));
    assign w_last_row  = (r_row == AW'(N_ROWS - 1));
    assign w_drain_end = (r_drain == DRW'(READ_LATENCY - 1));
    assign w_beat_sum  = mac8(romA_busA_in, romB_busA_in, romA_busB_in, romB_busB_in);
    assign w_a_addr    = AW2'(w_ld_row) * AW2'(N_COLS) + (AW2'(w_ld_beat) << 3);
    assign w_b_addr    = AW'(w_ld_beat) << 3;
    assign w_match     = (r_acc == romC_dataA_in);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clr_acc   = 1'b0;
        w_accept    = 1'b0;
        w_ld_row    = r_row;
        w_ld_beat   = '0;
        busy        = 1'b0;
        done        = 1'b0;
        w_check     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ISSUE;
                    w_load      = 1'b1;
                    w_clr_acc   = 1'b1;
                    w_accept    = 1'b1;
                    w_ld_row    = '0;
                end
            end
            S_ISSUE: begin
                busy = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = (READ_LATENCY == 0) ? S_CHECK : S_DRAIN;
                end else begin
                    w_load    = 1'b1;
                    w_ld_beat = r_beat + BW'(1);
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_drain_end) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                busy    = 1'b1;
                w_check = 1'b1;
                if (w_last_row) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_ISSUE;
                    w_load      = 1'b1;
                    w_clr_acc   = 1'b1;
                    w_ld_row    = r_row + AW'(1);
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Address stage: beat addresses and the valid token enter together.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_row      <= '0;
            r_beat     <= '0;
            r_a_addr_a <= '0;
            r_a_addr_b <= '0;
            r_b_addr_a <= '0;
            r_b_addr_b <= '0;
            r_vld_p    <= '0;
            r_drain    <= '0;
        end else begin
            if (w_load) begin
                r_row      <= w_ld_row;
                r_beat     <= w_ld_beat;
                r_a_addr_a <= w_a_addr;
                r_a_addr_b <= w_a_addr + AW2'(4);
                r_b_addr_a <= w_b_addr;
                r_b_addr_b <= w_b_addr + AW'(4);
            end
            r_vld_p[0] <= w_load;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
            end
            r_drain <= (r_state == S_DRAIN) ? r_drain + DRW'(1) : '0;
        end
    end

    // Accumulate stage: the oldest valid token qualifies the returning ROM data.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc      <= '0;
            r_mismatch <= '0;
        end else begin
            if (w_clr_acc) begin
                r_acc <= '0;
            end else if (r_vld_p[READ_LATENCY]) begin
                r_acc <= r_acc + w_beat_sum;
            end
            if (w_accept) begin
                r_mismatch <= '0;
            end else if (w_check && !w_match) begin
                r_mismatch <= sat_inc(r_mismatch);
            end
        end
    end

    assign romA_addrA     = r_a_addr_a;
    assign romA_addrB     = r_a_addr_b;
    assign romB_addrA     = r_b_addr_a;
    assign romB_addrB     = r_b_addr_b;
    assign romC_addrA     = r_row;
    assign romC_addrB     = r_row;
    assign result_valid   = w_check;
    assign result_row     = w_check ? r_row : '0;
    assign result_data    = w_check ? r_acc : '0;
    assign result_match   = w_check && w_match;
    assign mismatch_count = r_mismatch;

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Directed bench for matrix_mac_sequencer with a READ_LATENCY=2 ROM bank model.
module tb_matrix_mac_sequencer;

    localparam int DW = 8;
    localparam int AW = 7;
    localparam int NR = 128;
    localparam int NC = 128;
    localparam int RL = 2;
    localparam int ROW_CYC = NC / 8 + RL + 1;
    localparam int RUN_CYC = NR * ROW_CYC;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    logic [2*AW-1:0]   romA_addrA, romA_addrB;
    logic [AW-1:0]     romB_addrA, romB_addrB, romC_addrA, romC_addrB;
    logic [3:0][DW-1:0] a_a_s1 = '0, a_a_s2 = '0, a_b_s1 = '0, a_b_s2 = '0;
    logic [3:0][DW-1:0] b_a_s1 = '0, b_a_s2 = '0, b_b_s1 = '0, b_b_s2 = '0;
    logic [2*DW-1:0]   c_s1 = '0, c_s2 = '0;
    logic              busy, done, result_valid, result_match;
    logic [AW-1:0]     result_row;
    logic [2*DW-1:0]   result_data;
    logic [AW:0]       mismatch_count;

    logic [DW-1:0]     mem_a [0:NR*NC-1];
    logic [DW-1:0]     mem_b [0:NC-1];
    logic [2*DW-1:0]   mem_c [0:NR-1];

    int n_checks = 0;
    int n_errors = 0;

    int              cap_cnt;
    int              cap_done;
    logic            cap_busy0;
    logic [AW:0]     cap_mism0;
    logic            cap_done_after;
    logic            cap_busy_after;
    int              res_row   [0:255];
    logic [2*DW-1:0] res_data  [0:255];
    logic            res_match [0:255];

    matrix_mac_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_ROWS(NR), .N_COLS(NC), .READ_LATENCY(RL)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .romA_addrA(romA_addrA), .romA_addrB(romA_addrB),
        .romB_addrA(romB_addrA), .romB_addrB(romB_addrB),
        .romC_addrA(romC_addrA), .romC_addrB(romC_addrB),
        .romA_busA_in(a_a_s2), .romA_busB_in(a_b_s2),
        .romB_busA_in(b_a_s2), .romB_busB_in(b_b_s2),
        .romC_dataA_in(c_s2), .romC_dataB_in(c_s2),
        .busy(busy), .done(done), .result_valid(result_valid),
        .result_row(result_row), .result_data(result_data),
        .result_match(result_match), .mismatch_count(mismatch_count)
    );

    always #5 clock = ~clock;

    // ROM bank: two register stages between address and data.
    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            a_a_s1[i] <= mem_a[int'(romA_addrA) + i];
            a_b_s1[i] <= mem_a[int'(romA_addrB) + i];
            b_a_s1[i] <= mem_b[int'(romB_addrA) + i];
            b_b_s1[i] <= mem_b[int'(romB_addrB) + i];
        end
        c_s1   <= mem_c[int'(romC_addrA)];
        a_a_s2 <= a_a_s1;
        a_b_s2 <= a_b_s1;
        b_a_s2 <= b_a_s1;
        b_b_s2 <= b_b_s1;
        c_s2   <= c_s1;
    end

    // Mode 0: A[r][k]=r+k, B[k]=k, so C[r] = r*8128 + 690880 (mod 65536).
    // Mode 1: everything 0xFF, so C[r] = 128*65025 mod 65536 = 0x0080.
    function automatic logic [2*DW-1:0] exp_c(input int mode, input int r);
        return (mode == 0) ? 16'(r * 8128 + 35520) : 16'h0080;
    endfunction

    task automatic load_pattern(input int mode);
        for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < NC; k++) begin
                mem_a[r*NC + k] = (mode == 0) ? 8'(r + k) : 8'hFF;
            end
            mem_c[r] = exp_c(mode, r);
        end
        for (int k = 0; k < NC; k++) begin
            mem_b[k] = (mode == 0) ? 8'(k) : 8'hFF;
        end
    endtask

    // Starts a run and records every result pulse; cap_done stays -1 on timeout.
    task automatic run_capture(input int max_cyc, input int restart_at);
        int n;
        cap_cnt  = 0;
        cap_done = -1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (cap_done < 0 && n < max_cyc) begin
            if (n == 0) begin
                cap_busy0 = busy;
                cap_mism0 = mismatch_count;
            end
            if (result_valid) begin
                if (cap_cnt < 256) begin
                    res_row[cap_cnt]   = int'(result_row);
                    res_data[cap_cnt]  = result_data;
                    res_match[cap_cnt] = result_match;
                end
                cap_cnt++;
            end
            if (done) cap_done = n;
            start = (n == restart_at);
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        cap_done_after = done;
        cap_busy_after = busy;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        n_checks++; if (result_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid: got %0b expected 0", result_valid); end
        n_checks++; if (result_row !== 7'd0) begin n_errors++; $display("FAIL reset_rrow: got %0d expected 0", result_row); end
        n_checks++; if (result_data !== 16'd0) begin n_errors++; $display("FAIL reset_rdata: got %0h expected 0", result_data); end
        n_checks++; if (result_match !== 1'b0) begin n_errors++; $display("FAIL reset_rmatch: got %0b expected 0", result_match); end
        n_checks++; if (mismatch_count !== 8'd0) begin n_errors++; $display("FAIL reset_mism: got %0d expected 0", mismatch_count); end
        n_checks++; if (romA_addrA !== 14'd0 || romA_addrB !== 14'd0) begin n_errors++; $display("FAIL reset_addrA: got %0d/%0d expected 0/0", romA_addrA, romA_addrB); end
        n_checks++; if (romB_addrA !== 7'd0 || romB_addrB !== 7'd0) begin n_errors++; $display("FAIL reset_addrB: got %0d/%0d expected 0/0", romB_addrA, romB_addrB); end
        n_checks++; if (romC_addrA !== 7'd0 || romC_addrB !== 7'd0) begin n_errors++; $display("FAIL reset_addrC: got %0d/%0d expected 0/0", romC_addrA, romC_addrB); end
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_start_ignored: busy %0b expected 0", busy); end
    endtask

    task automatic test_addr_sweep;
        load_pattern(0);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int j = 0; j < NC / 8; j++) begin
            n_checks++; if (romA_addrA !== 14'(8*j)) begin n_errors++; $display("FAIL sweep_romA_addrA beat %0d: got %0d expected %0d", j, romA_addrA, 8*j); end
            n_checks++; if (romA_addrB !== 14'(8*j + 4)) begin n_errors++; $display("FAIL sweep_romA_addrB beat %0d: got %0d expected %0d", j, romA_addrB, 8*j + 4); end
            n_checks++; if (romB_addrA !== 7'(8*j)) begin n_errors++; $display("FAIL sweep_romB_addrA beat %0d: got %0d expected %0d", j, romB_addrA, 8*j); end
            n_checks++; if (romB_addrB !== 7'(8*j + 4)) begin n_errors++; $display("FAIL sweep_romB_addrB beat %0d: got %0d expected %0d", j, romB_addrB, 8*j + 4); end
            n_checks++; if (romC_addrA !== 7'd0 || romC_addrB !== 7'd0) begin n_errors++; $display("FAIL sweep_romC beat %0d: got %0d/%0d expected 0/0", j, romC_addrA, romC_addrB); end
            @(negedge clock);
        end
        n_checks++; if (romA_addrA !== 14'd120 || busy !== 1'b1) begin n_errors++; $display("FAIL sweep_drain_hold: addr %0d busy %0b expected 120 1", romA_addrA, busy); end
        repeat (2) @(negedge clock);
        n_checks++; if (result_valid !== 1'b1 || result_row !== 7'd0) begin n_errors++; $display("FAIL sweep_check_row0: valid %0b row %0d expected 1 0", result_valid, result_row); end
        @(negedge clock);
        n_checks++; if (romA_addrA !== 14'd128 || romA_addrB !== 14'd132) begin n_errors++; $display("FAIL sweep_row1_addrA: got %0d/%0d expected 128/132", romA_addrA, romA_addrB); end
        n_checks++; if (romB_addrA !== 7'd0 || romC_addrA !== 7'd1) begin n_errors++; $display("FAIL sweep_row1_BC: got %0d/%0d expected 0/1", romB_addrA, romC_addrA); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_full_run;
        load_pattern(0);
        run_capture(RUN_CYC + 500, -1);
        n_checks++; if (cap_busy0 !== 1'b1) begin n_errors++; $display("FAIL full_busy_first: got %0b expected 1", cap_busy0); end
        n_checks++; if (cap_done != RUN_CYC) begin n_errors++; $display("FAIL full_done_cycle: got %0d expected %0d", cap_done, RUN_CYC); end
        n_checks++; if (cap_cnt != NR) begin n_errors++; $display("FAIL full_result_count: got %0d expected %0d", cap_cnt, NR); end
        for (int i = 0; i < NR; i++) begin
            n_checks++; if (res_row[i] != i) begin n_errors++; $display("FAIL full_row %0d: got %0d expected %0d", i, res_row[i], i); end
            n_checks++; if (res_data[i] !== exp_c(0, i)) begin n_errors++; $display("FAIL full_data row %0d: got %0h expected %0h", i, res_data[i], exp_c(0, i)); end
            n_checks++; if (res_match[i] !== 1'b1) begin n_errors++; $display("FAIL full_match row %0d: got %0b expected 1", i, res_match[i]); end
        end
        n_checks++; if (mismatch_count !== 8'd0) begin n_errors++; $display("FAIL full_mism: got %0d expected 0", mismatch_count); end
        n_checks++; if (cap_done_after !== 1'b0 || cap_busy_after !== 1'b0) begin n_errors++; $display("FAIL full_after_done: done %0b busy %0b expected 0 0", cap_done_after, cap_busy_after); end
    endtask

    task automatic test_corrupt;
        int n_match;
        load_pattern(0);
        mem_c[5] = mem_c[5] ^ 16'h0001;
        run_capture(RUN_CYC + 500, -1);
        n_match = 0;
        for (int i = 0; i < NR; i++) if (res_match[i] === 1'b1 && i != 5) n_match++;
        n_checks++; if (cap_cnt != NR) begin n_errors++; $display("FAIL corrupt_count: got %0d expected %0d", cap_cnt, NR); end
        n_checks++; if (res_match[5] !== 1'b0) begin n_errors++; $display("FAIL corrupt_row5_match: got %0b expected 0", res_match[5]); end
        n_checks++; if (res_data[5] !== 16'(5 * 8128 + 35520)) begin n_errors++; $display("FAIL corrupt_row5_data: got %0h expected %0h", res_data[5], 16'(5 * 8128 + 35520)); end
        n_checks++; if (n_match != NR - 1) begin n_errors++; $display("FAIL corrupt_other_rows: got %0d matching expected %0d", n_match, NR - 1); end
        n_checks++; if (mismatch_count !== 8'd1) begin n_errors++; $display("FAIL corrupt_mism: got %0d expected 1", mismatch_count); end
        mem_c[5] = exp_c(0, 5);
    endtask

    task automatic test_overflow;
        load_pattern(1);
        run_capture(RUN_CYC + 500, -1);
        n_checks++; if (cap_mism0 !== 8'd0) begin n_errors++; $display("FAIL ovf_mism_cleared: got %0d expected 0", cap_mism0); end
        n_checks++; if (cap_cnt != NR) begin n_errors++; $display("FAIL ovf_count: got %0d expected %0d", cap_cnt, NR); end
        for (int i = 0; i < NR; i += 9) begin
            n_checks++; if (res_data[i] !== 16'h0080) begin n_errors++; $display("FAIL ovf_data row %0d: got %0h expected 0080", i, res_data[i]); end
        end
        n_checks++; if (res_data[NR-1] !== 16'h0080 || res_match[NR-1] !== 1'b1) begin n_errors++; $display("FAIL ovf_last_row: got %0h/%0b expected 0080/1", res_data[NR-1], res_match[NR-1]); end
        n_checks++; if (mismatch_count !== 8'd0) begin n_errors++; $display("FAIL ovf_mism: got %0d expected 0", mismatch_count); end
    endtask

    task automatic test_start_midrun;
        int bad_rows;
        load_pattern(0);
        run_capture(RUN_CYC + 500, 300);
        bad_rows = 0;
        for (int i = 0; i < NR; i++) if (res_row[i] != i) bad_rows++;
        n_checks++; if (cap_done != RUN_CYC) begin n_errors++; $display("FAIL midstart_done_cycle: got %0d expected %0d", cap_done, RUN_CYC); end
        n_checks++; if (cap_cnt != NR) begin n_errors++; $display("FAIL midstart_count: got %0d expected %0d", cap_cnt, NR); end
        n_checks++; if (bad_rows != 0) begin n_errors++; $display("FAIL midstart_row_order: got %0d out-of-order rows expected 0", bad_rows); end
        run_capture(RUN_CYC + 500, RUN_CYC);
        @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL start_in_done_ignored: busy %0b expected 0", busy); end
    endtask

    task automatic test_back_to_back;
        run_capture(RUN_CYC + 500, -1);
        n_checks++; if (cap_done != RUN_CYC || cap_cnt != NR) begin n_errors++; $display("FAIL b2b_run: done %0d count %0d expected %0d %0d", cap_done, cap_cnt, RUN_CYC, NR); end
        n_checks++; if (res_data[77] !== exp_c(0, 77)) begin n_errors++; $display("FAIL b2b_row77: got %0h expected %0h", res_data[77], exp_c(0, 77)); end
    endtask

    task automatic test_reset_midrun;
        int done_seen;
        load_pattern(0);
        mem_c[5] = mem_c[5] ^ 16'h0001;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (500) @(negedge clock);
        n_checks++; if (mismatch_count !== 8'd1 || busy !== 1'b1) begin n_errors++; $display("FAIL rstmid_before: mism %0d busy %0b expected 1 1", mismatch_count, busy); end
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_ctrl: busy %0b done %0b valid %0b expected 0 0 0", busy, done, result_valid); end
        n_checks++; if (romA_addrA !== 14'd0 || romC_addrA !== 7'd0 || mismatch_count !== 8'd0) begin n_errors++; $display("FAIL rstmid_regs: addrA %0d addrC %0d mism %0d expected 0 0 0", romA_addrA, romC_addrA, mismatch_count); end
        reset = 1'b0;
        mem_c[5] = exp_c(0, 5);
        done_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        n_checks++; if (done_seen != 0) begin n_errors++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", done_seen); end
        run_capture(RUN_CYC + 500, -1);
        n_checks++; if (cap_done != RUN_CYC || cap_cnt != NR) begin n_errors++; $display("FAIL rstmid_rerun: done %0d count %0d expected %0d %0d", cap_done, cap_cnt, RUN_CYC, NR); end
        n_checks++; if (mismatch_count !== 8'd0 || res_match[5] !== 1'b1) begin n_errors++; $display("FAIL rstmid_rerun_clean: mism %0d match5 %0b expected 0 1", mismatch_count, res_match[5]); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        load_pattern(0);
        test_reset();
        test_addr_sweep();
        test_full_run();
        test_corrupt();
        test_overflow();
        test_start_midrun();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
